// File: rtl/gpio_bus_arbiter_if.sv
// rtl/gpio_bus_arbiter_if.sv - requester and gpio-side signal bundle for gpio_bus_arbiter
interface gpio_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            m_req;
    logic [2*NUM_MASTERS-1:0]          m_op;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]            m_ack;
    logic [DATA_WIDTH-1:0]             m_rdata;
    logic                              busy;
    logic [ADDR_WIDTH-1:0]             gpio_addr;
    logic [DATA_WIDTH-1:0]             gpio_wdata;
    logic                              gpio_we;
    logic                              gpio_re;
    logic [DATA_WIDTH-1:0]             gpio_rdata;

    // slave: the arbiter itself; master: requesters plus the gpio instance around it
    modport slave (
        input  m_req, m_op, m_addr, m_wdata, gpio_rdata,
        output m_ack, m_rdata, busy, gpio_addr, gpio_wdata, gpio_we, gpio_re
    );

    modport master (
        output m_req, m_op, m_addr, m_wdata, gpio_rdata,
        input  m_ack, m_rdata, busy, gpio_addr, gpio_wdata, gpio_we, gpio_re
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// rtl/gpio_bus_arbiter.sv - round-robin arbiter sharing one gpio register port, with locked set/clear RMW
module gpio_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input logic               clk,
    input logic               rst_n,
    gpio_bus_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_MASTERS > 2) ? 2 : 1;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0]      ptr_q, g_q, win_idx;
    logic                  win_valid;
    logic [1:0]            win_op, op_q;
    logic [ADDR_WIDTH-1:0] win_addr, addr_q;
    logic [DATA_WIDTH-1:0] win_wdata, wdata_q, rbuf_q, rdata_q;
    int                    scan_idx;

    // Scan from the farthest slot down so the nearest requester after ptr wins last.
    always_comb begin
        scan_idx  = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        win_op    = '0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            scan_idx = (int'(ptr_q) + k) % NUM_MASTERS;
            if (bus.m_req[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(scan_idx);
                win_op    = bus.m_op[2*scan_idx +: 2];
                win_addr  = bus.m_addr[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = bus.m_wdata[scan_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= IDX_W'(NUM_MASTERS - 1);
            g_q     <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        g_q     <= win_idx;
                        op_q    <= win_op;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                    end
                end
                READ: begin
                    rbuf_q <= bus.gpio_rdata;
                    if (op_q == OP_READ) begin
                        rdata_q <= bus.gpio_rdata;
                    end
                end
                // set/clear hand back the pre-modify value; plain writes return zero
                WRITE: rdata_q <= (op_q == OP_WRITE) ? '0 : rbuf_q;
                ACK:   ptr_q   <= g_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.busy       = (state_q != IDLE);
        bus.gpio_re    = 1'b0;
        bus.gpio_we    = 1'b0;
        bus.gpio_addr  = '0;
        bus.gpio_wdata = '0;
        bus.m_ack      = '0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = (win_op == OP_WRITE) ? WRITE : READ;
                end
            end
            READ: begin
                bus.gpio_re   = 1'b1;
                bus.gpio_addr = addr_q;
                state_d       = (op_q == OP_READ) ? ACK : WRITE;
            end
            WRITE: begin
                bus.gpio_we   = 1'b1;
                bus.gpio_addr = addr_q;
                case (op_q)
                    OP_SET:  bus.gpio_wdata = rbuf_q | wdata_q;
                    OP_CLR:  bus.gpio_wdata = rbuf_q & ~wdata_q;
                    default: bus.gpio_wdata = wdata_q;
                endcase
                state_d = ACK;
            end
            ACK: begin
                bus.m_ack[g_q] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.m_rdata = rdata_q;
endmodule

// File: doc/gpio_bus_arbiter.md
Name: gpio_bus_arbiter

Overview:
Shares one gpio register interface (addr/write_data/write_en/read_en/read_data) among NUM_MASTERS requesters, e.g. CPU, DMA and a debug port. Uses round-robin arbitration with a req/ack handshake. Adds atomic set-bits and clear-bits operations, sequenced as a locked read-modify-write. No other master can interleave between the read and the write. Sits between the system bus fabric and the gpio instance.

Parameters:
NUM_MASTERS, 2, number of requesters; legal range 2..4.
ADDR_WIDTH, 32, address width; matches gpio.
DATA_WIDTH, 32, data width; matches gpio.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
m_req  in  NUM_MASTERS  per-master request; held high with command stable until ack
m_op  in  2*NUM_MASTERS  per-master op, slice [2i+1:2i]: 00 read, 01 write, 10 set-bits, 11 clear-bits
m_addr  in  NUM_MASTERS*ADDR_WIDTH  per-master register address
m_wdata  in  NUM_MASTERS*DATA_WIDTH  per-master write data, or bit mask for set/clear
m_ack  out  NUM_MASTERS  one-cycle completion pulse to the served master
m_rdata  out  DATA_WIDTH  shared read-return bus; valid in the ack cycle, holds value until next ack
busy  out  1  high in every non-IDLE state
gpio_addr  out  ADDR_WIDTH  to gpio addr
gpio_wdata  out  DATA_WIDTH  to gpio write_data
gpio_we  out  1  to gpio write_en
gpio_re  out  1  to gpio read_en
gpio_rdata  in  DATA_WIDTH  from gpio read_data; combinational in the same cycle as gpio_re

Behaviour:
- Reset values: all outputs 0. State IDLE. Round-robin pointer = NUM_MASTERS-1, so master 0 has first priority. Latched command registers and rbuf = 0.
- FSM states: IDLE, READ, WRITE, ACK. All registered. Only one grant is outstanding at a time.
- IDLE:
  - If any m_req bit is set, choose the first requester searching from (ptr+1) mod NUM_MASTERS upward, with wrap-around.
  - Latch grant index g, op, addr and wdata of the winner.
  - Next state: WRITE if op=01, otherwise READ.
  - If no request, stay in IDLE.
- READ:
  - gpio_re=1, gpio_addr=latched addr.
  - Capture gpio_rdata into rbuf at the end of the cycle.
  - Next state: ACK for op=00; WRITE for op=10/11.
- WRITE:
  - gpio_we=1, gpio_addr=latched addr.
  - gpio_wdata = wdata for op=01; rbuf|wdata for op=10; rbuf&~wdata for op=11.
  - Next state: ACK.
- ACK:
  - m_ack[g]=1 for exactly one cycle.
  - m_rdata = rbuf for ops 00/10/11, so set/clear return the pre-modify value. m_rdata = 0 for op 01.
  - ptr <= g. Next state: IDLE.
- gpio_we and gpio_re are never high in the same cycle. In IDLE and ACK, gpio_addr and gpio_wdata drive 0.
- Latency, counting the IDLE sampling cycle as cycle 0:
  - read: ack in cycle 2.
  - write: ack in cycle 2.
  - set/clear: ack in cycle 3.
  - Back-to-back throughput: one op per 3 cycles (read/write) or 4 cycles (set/clear).
- A master must deassert m_req in the cycle after its ack unless it is issuing a new command. A req still high in the next IDLE cycle is treated as a new command.
- Requests arriving while busy wait in the request line; they are not lost. m_req/m_op changes by non-granted masters while busy have no effect.
- Changes to the granted master's command after IDLE have no effect, because the command is latched.
- Interrupt-status write-1-to-clear at gpio address 4 works through op=01. set/clear on address 4 is legal but not meaningful; it is not blocked.
- Asynchronous reset mid-operation: the transaction is aborted with no ack. Outputs go to 0 immediately and ptr resets. A half-done read-modify-write leaves gpio unmodified if reset hits during READ.

Test Plan:
- Single read: master 0 reads addr 2 while gpio direction=0x00FF -> gpio_re high 1 cycle, m_ack[0] in cycle 2, m_rdata=0x000000FF.
- Write: master 1 op=01, addr 0, wdata 0xAA -> gpio_we 1 cycle with gpio_wdata=0xAA, m_ack[1] in cycle 2, m_rdata=0.
- Set/clear RMW: data_out=0x00F0. Master 0 set mask 0x000F -> gpio write 0x00FF, m_rdata=0x00F0. Then clear mask 0x0030 -> gpio write 0x00CF, m_rdata=0x00FF. Each ack is in cycle 3.
- Round-robin: both masters hold req continuously with reads -> grants alternate 0,1,0,1; ack pulses are 3 cycles apart and never overlap.
- Atomicity: master 1 requests during master 0's set op -> no gpio access for master 1 until master 0's ack; master 1's read returns the post-write value.
- Reset during WRITE of a write op -> no ack. All outputs 0 and busy=0 the same cycle. After release, master 0 wins first.
